// File: rtl/rv_pkg.sv
// Shared encodings for the RV32I multi-cycle controller:
// opcodes, ALU ops, datapath selects, FSM states, control bundle.
package rv_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SLL  = 4'd6;
    localparam logic [3:0] ALU_SRL  = 4'd7;
    localparam logic [3:0] ALU_SRA  = 4'd8;
    localparam logic [3:0] ALU_SLT  = 4'd9;
    localparam logic [3:0] ALU_SLTU = 4'd10;

    localparam logic [1:0] A_PC    = 2'd0;
    localparam logic [1:0] A_OLDPC = 2'd1;
    localparam logic [1:0] A_RS1   = 2'd2;

    localparam logic [1:0] B_RS2  = 2'd0;
    localparam logic [1:0] B_IMM  = 2'd1;
    localparam logic [1:0] B_FOUR = 2'd2;

    localparam logic [1:0] WB_ALUOUT = 2'd0;
    localparam logic [1:0] WB_MDR    = 2'd1;
    localparam logic [1:0] WB_IMM    = 2'd2;
    localparam logic [1:0] WB_PC     = 2'd3;

    localparam logic PC_ALU    = 1'b0;
    localparam logic PC_ALUOUT = 1'b1;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd5;

    typedef enum logic [1:0] {
        CL_ADD,
        CL_REG,
        CL_IMM,
        CL_BRANCH
    } opclass_t;

    typedef struct packed {
        logic [3:0] alu_src;
        logic [1:0] alu_a_sel;
        logic [1:0] alu_b_sel;
        logic       pc_write;
        logic       pc_sel;
        logic       opc_write;
        logic       ir_write;
        logic       mem_req;
        logic       mem_we;
        logic       mem_addr_sel;
        logic       mdr_write;
        logic       reg_write;
        logic [1:0] wb_sel;
    } ctrl_t;

    function automatic logic [3:0] alu_from_f3(
        input logic [2:0] f3,
        input logic       alt
    );
        logic [3:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rv_mc_ctrl_if.sv
// Controller <-> datapath bundle: IR, memory ready, branch flags
// in; ALU op, selects and write enables out.
interface rv_mc_ctrl_if;

    logic [31:0] instr;
    logic        mem_ready;
    logic        br_eq;
    logic        br_lt;
    logic        br_ltu;
    logic [3:0]  alu_src;
    logic [1:0]  alu_a_sel;
    logic [1:0]  alu_b_sel;
    logic        pc_write;
    logic        pc_sel;
    logic        opc_write;
    logic        ir_write;
    logic        mem_req;
    logic        mem_we;
    logic        mem_addr_sel;
    logic        mdr_write;
    logic        reg_write;
    logic [1:0]  wb_sel;
    logic        illegal;

    modport master (
        input  instr, mem_ready, br_eq, br_lt, br_ltu,
        output alu_src, alu_a_sel, alu_b_sel,
        output pc_write, pc_sel, opc_write, ir_write,
        output mem_req, mem_we, mem_addr_sel, mdr_write,
        output reg_write, wb_sel, illegal
    );

    modport slave (
        output instr, mem_ready, br_eq, br_lt, br_ltu,
        input  alu_src, alu_a_sel, alu_b_sel,
        input  pc_write, pc_sel, opc_write, ir_write,
        input  mem_req, mem_we, mem_addr_sel, mdr_write,
        input  reg_write, wb_sel, illegal
    );

endinterface

// File: rtl/rv_alu_decoder.sv
// Maps opcode class, funct3 and funct7 to an ALU op and flags
// encodings that RV32I leaves reserved.
module rv_alu_decoder
    import rv_pkg::*;
(
    input  opclass_t   cls,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [3:0] alu_op,
    output logic       reserved
);

    logic f7_ok;
    logic shift;

    assign f7_ok = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
    assign shift = (funct3 == 3'b001) || (funct3 == 3'b101);

    // Per-class op selection; the alternate bit only matters where defined
    always_comb begin
        alu_op   = ALU_ADD;
        reserved = 1'b0;
        unique case (1'b1)
            (cls == CL_REG): begin
                alu_op   = alu_from_f3(funct3, funct7[5]);
                reserved = !f7_ok ||
                           (funct7[5] && (funct3 != 3'b000) &&
                            (funct3 != 3'b101));
            end
            (cls == CL_IMM): begin
                alu_op   = alu_from_f3(funct3,
                                       (funct3 == 3'b101) && funct7[5]);
                reserved = shift && !f7_ok;
            end
            (cls == CL_BRANCH): begin
                alu_op   = ALU_SUB;
                reserved = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            default: begin
                alu_op   = ALU_ADD;
                reserved = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/rv_mc_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch, decode, execute,
// memory and writeback, and drives the ALU op and operand selects.
module rv_mc_ctrl
    import rv_pkg::*;
#(
    parameter bit ENABLE_FENCE   = 1'b1,
    parameter bit TRAP_ON_SYSTEM = 1'b1
) (
    input logic           clk,
    input logic           rst_n,
    rv_mc_ctrl_if.master  bus
);

    logic [2:0] state;
    logic [2:0] nxt;
    logic       illegal_q;
    ctrl_t      c;
    ctrl_t      g;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    opclass_t   cls;
    logic [3:0] dec_op;
    logic       reserved;
    logic       legal;
    logic       taken;

    logic is_lui, is_auipc, is_jal, is_jalr, is_branch;
    logic is_load, is_store, is_imm, is_reg, is_fence, is_system;

    wire unused_instr = ^{bus.instr[24:15], bus.instr[11:7]};

    assign opcode = bus.instr[6:0];
    assign funct3 = bus.instr[14:12];
    assign funct7 = bus.instr[31:25];

    assign is_lui    = opcode == OP_LUI;
    assign is_auipc  = opcode == OP_AUIPC;
    assign is_jal    = opcode == OP_JAL;
    assign is_jalr   = opcode == OP_JALR;
    assign is_branch = opcode == OP_BRANCH;
    assign is_load   = opcode == OP_LOAD;
    assign is_store  = opcode == OP_STORE;
    assign is_imm    = opcode == OP_IMM;
    assign is_reg    = opcode == OP_REG;
    assign is_fence  = opcode == OP_FENCE;
    assign is_system = opcode == OP_SYSTEM;

    assign legal = is_lui | is_auipc | is_jal | is_jalr | is_branch |
                   is_load | is_store | is_imm | is_reg | is_system |
                   (is_fence & ENABLE_FENCE);

    // Opcode class feeding the ALU decoder
    always_comb begin
        cls = CL_ADD;
        unique case (1'b1)
            is_reg:    cls = CL_REG;
            is_imm:    cls = CL_IMM;
            is_branch: cls = CL_BRANCH;
            default:   cls = CL_ADD;
        endcase
    end

    rv_alu_decoder u_dec (
        .cls      (cls),
        .funct3   (funct3),
        .funct7   (funct7),
        .alu_op   (dec_op),
        .reserved (reserved)
    );

    // Branch condition from funct3 and the ALU comparison flags
    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = bus.br_eq;
            3'b001:  taken = !bus.br_eq;
            3'b100:  taken = bus.br_lt;
            3'b101:  taken = !bus.br_lt;
            3'b110:  taken = bus.br_ltu;
            3'b111:  taken = !bus.br_ltu;
            default: taken = 1'b0;
        endcase
    end

    // Control outputs and next state for the current state
    always_comb begin
        c   = '0;
        nxt = state;
        case (state)
            S_FETCH: begin
                c.mem_req   = 1'b1;
                c.alu_a_sel = A_PC;
                c.alu_b_sel = B_FOUR;
                c.alu_src   = ALU_ADD;
                if (bus.mem_ready) begin
                    c.ir_write  = 1'b1;
                    c.opc_write = 1'b1;
                    c.pc_write  = 1'b1;
                    c.pc_sel    = PC_ALU;
                    nxt         = S_DECODE;
                end
            end
            S_DECODE: begin
                c.alu_a_sel = A_OLDPC;
                c.alu_b_sel = B_IMM;
                c.alu_src   = ALU_ADD;
                if (!legal || reserved)
                    nxt = S_TRAP;
                else if (is_system && TRAP_ON_SYSTEM)
                    nxt = S_TRAP;
                else
                    nxt = S_EXEC;
            end
            S_EXEC: begin
                c.alu_src   = dec_op;
                c.alu_a_sel = A_OLDPC;
                c.alu_b_sel = B_IMM;
                nxt         = S_FETCH;
                unique case (1'b1)
                    is_reg: begin
                        c.alu_a_sel = A_RS1;
                        c.alu_b_sel = B_RS2;
                        nxt         = S_WB;
                    end
                    is_imm: begin
                        c.alu_a_sel = A_RS1;
                        nxt         = S_WB;
                    end
                    (is_load || is_store): begin
                        c.alu_a_sel = A_RS1;
                        nxt         = S_MEM;
                    end
                    is_branch: begin
                        c.alu_a_sel = A_RS1;
                        c.alu_b_sel = B_RS2;
                        c.pc_write  = taken;
                        c.pc_sel    = PC_ALUOUT;
                    end
                    is_jal: begin
                        c.reg_write = 1'b1;
                        c.wb_sel    = WB_PC;
                        c.pc_write  = 1'b1;
                        c.pc_sel    = PC_ALUOUT;
                    end
                    is_jalr: begin
                        c.alu_a_sel = A_RS1;
                        c.reg_write = 1'b1;
                        c.wb_sel    = WB_PC;
                        c.pc_write  = 1'b1;
                        c.pc_sel    = PC_ALU;
                    end
                    is_lui: begin
                        c.reg_write = 1'b1;
                        c.wb_sel    = WB_IMM;
                    end
                    is_auipc: begin
                        c.reg_write = 1'b1;
                        c.wb_sel    = WB_ALUOUT;
                    end
                    default: nxt = S_FETCH;
                endcase
            end
            S_MEM: begin
                c.alu_src      = ALU_ADD;
                c.alu_a_sel    = A_RS1;
                c.alu_b_sel    = B_IMM;
                c.mem_req      = 1'b1;
                c.mem_addr_sel = 1'b1;
                c.mem_we       = is_store;
                if (bus.mem_ready) begin
                    c.mdr_write = is_load;
                    nxt         = is_load ? S_WB : S_FETCH;
                end
            end
            S_WB: begin
                c.alu_src   = dec_op;
                c.alu_a_sel = A_RS1;
                c.alu_b_sel = is_reg ? B_RS2 : B_IMM;
                c.reg_write = 1'b1;
                c.wb_sel    = is_load ? WB_MDR : WB_ALUOUT;
                nxt         = S_FETCH;
            end
            S_TRAP: begin
                nxt = S_TRAP;
            end
            default: nxt = S_FETCH;
        endcase
    end

    // State and sticky illegal flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state <= nxt;
            if (state == S_DECODE && nxt == S_TRAP)
                illegal_q <= 1'b1;
        end
    end

    assign g = rst_n ? c : '0;

    assign bus.alu_src      = g.alu_src;
    assign bus.alu_a_sel    = g.alu_a_sel;
    assign bus.alu_b_sel    = g.alu_b_sel;
    assign bus.pc_write     = g.pc_write;
    assign bus.pc_sel       = g.pc_sel;
    assign bus.opc_write    = g.opc_write;
    assign bus.ir_write     = g.ir_write;
    assign bus.mem_req      = g.mem_req;
    assign bus.mem_we       = g.mem_we;
    assign bus.mem_addr_sel = g.mem_addr_sel;
    assign bus.mdr_write    = g.mdr_write;
    assign bus.reg_write    = g.reg_write;
    assign bus.wb_sel       = g.wb_sel;
    assign bus.illegal      = rst_n & illegal_q;

endmodule

// File: tb/tb_rv_mc_ctrl.sv
// Directed bench for rv_mc_ctrl: walks instructions through the
// FSM and checks controls mid-cycle against hand-derived values.
module tb_rv_mc_ctrl;

    localparam logic [31:0] FETCH  = 32'd0;
    localparam logic [31:0] DECODE = 32'd1;
    localparam logic [31:0] EXEC   = 32'd2;
    localparam logic [31:0] MEM    = 32'd3;
    localparam logic [31:0] WB     = 32'd4;
    localparam logic [31:0] TRAP   = 32'd5;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   rw_cnt;
    int   rw_base;

    rv_mc_ctrl_if bus ();

    rv_mc_ctrl #(
        .ENABLE_FENCE   (1'b1),
        .TRAP_ON_SYSTEM (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk)
        if (bus.reg_write) rw_cnt++;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic to_exec(input logic [31:0] ins);
        bus.instr     = ins;
        bus.mem_ready = 1'b1;
        #1;
        check("fetch_state", 32'(dut.state), FETCH);
        step();
        check("decode_state", 32'(dut.state), DECODE);
        step();
        check("exec_state", 32'(dut.state), EXEC);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rw_cnt    = 0;
        rst_n     = 1'b0;
        bus.instr = 32'h0;
        bus.mem_ready = 1'b1;
        bus.br_eq  = 1'b0;
        bus.br_lt  = 1'b0;
        bus.br_ltu = 1'b0;
        #7;
        check("rst_state", 32'(dut.state), FETCH);
        check("rst_mem_req", 32'(bus.mem_req), 0);
        check("rst_ir_write", 32'(bus.ir_write), 0);
        check("rst_pc_write", 32'(bus.pc_write), 0);
        check("rst_illegal", 32'(bus.illegal), 0);
        check("rst_b_sel", 32'(bus.alu_b_sel), 0);

        @(negedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("f_mem_req", 32'(bus.mem_req), 1);
        check("f_alu_src", 32'(bus.alu_src), 1);
        check("f_b_sel", 32'(bus.alu_b_sel), 2);
        check("f_ir_write", 32'(bus.ir_write), 1);
        check("f_opc_write", 32'(bus.opc_write), 1);
        check("f_pc_write", 32'(bus.pc_write), 1);

        // ADD x3,x1,x2
        rw_base = rw_cnt;
        to_exec(32'h002081B3);
        check("add_alu", 32'(bus.alu_src), 1);
        check("add_a", 32'(bus.alu_a_sel), 2);
        check("add_b", 32'(bus.alu_b_sel), 0);
        check("add_rw_exec", 32'(bus.reg_write), 0);
        step();
        check("add_wb_state", 32'(dut.state), WB);
        check("add_wb_rw", 32'(bus.reg_write), 1);
        check("add_wb_sel", 32'(bus.wb_sel), 0);
        step();
        check("add_back_fetch", 32'(dut.state), FETCH);
        check("add_rw_pulses", 32'(rw_cnt - rw_base), 1);

        // Fetch wait: nothing loads while memory is busy
        bus.mem_ready = 1'b0;
        #1;
        check("fw_mem_req", 32'(bus.mem_req), 1);
        check("fw_ir_write", 32'(bus.ir_write), 0);
        check("fw_pc_write", 32'(bus.pc_write), 0);
        step();
        check("fw_hold", 32'(dut.state), FETCH);

        // SUB
        to_exec(32'h402081B3);
        check("sub_alu", 32'(bus.alu_src), 2);
        step();
        step();

        // SRAI
        to_exec(32'h4020D193);
        check("srai_alu", 32'(bus.alu_src), 8);
        check("srai_b", 32'(bus.alu_b_sel), 1);
        step();
        step();

        // ADDI with imm[10] set must not subtract
        to_exec(32'h40008093);
        check("addi_alu", 32'(bus.alu_src), 1);
        step();
        step();

        // BLT taken
        bus.br_lt = 1'b1;
        to_exec(32'h0020C463);
        check("blt_t_alu", 32'(bus.alu_src), 2);
        check("blt_t_pcw", 32'(bus.pc_write), 1);
        check("blt_t_pcs", 32'(bus.pc_sel), 1);
        step();
        check("blt_t_fetch", 32'(dut.state), FETCH);

        // BLT not taken
        bus.br_lt = 1'b0;
        to_exec(32'h0020C463);
        check("blt_n_pcw", 32'(bus.pc_write), 0);
        step();
        check("blt_n_fetch", 32'(dut.state), FETCH);

        // BGEU with br_ltu=0 is taken
        bus.br_ltu = 1'b0;
        to_exec(32'h0020F463);
        check("bgeu_pcw", 32'(bus.pc_write), 1);
        step();

        // LW with three wait cycles in MEM
        to_exec(32'h0000A183);
        check("lw_alu", 32'(bus.alu_src), 1);
        check("lw_b", 32'(bus.alu_b_sel), 1);
        bus.mem_ready = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            check("lw_wait_state", 32'(dut.state), MEM);
            check("lw_wait_req", 32'(bus.mem_req), 1);
            check("lw_wait_asel", 32'(bus.mem_addr_sel), 1);
            check("lw_wait_mdr", 32'(bus.mdr_write), 0);
            check("lw_wait_rw", 32'(bus.reg_write), 0);
            step();
        end
        bus.mem_ready = 1'b1;
        #1;
        check("lw_rdy_req", 32'(bus.mem_req), 1);
        check("lw_rdy_mdr", 32'(bus.mdr_write), 1);
        check("lw_rdy_we", 32'(bus.mem_we), 0);
        step();
        check("lw_wb_state", 32'(dut.state), WB);
        check("lw_wb_rw", 32'(bus.reg_write), 1);
        check("lw_wb_sel", 32'(bus.wb_sel), 1);
        step();

        // SW goes straight back to FETCH after MEM
        to_exec(32'h0020A023);
        step();
        check("sw_we", 32'(bus.mem_we), 1);
        step();
        check("sw_fetch", 32'(dut.state), FETCH);

        // JALR: single EXEC cycle
        to_exec(32'h000080E7);
        check("jalr_rw", 32'(bus.reg_write), 1);
        check("jalr_wb", 32'(bus.wb_sel), 3);
        check("jalr_pcw", 32'(bus.pc_write), 1);
        check("jalr_pcs", 32'(bus.pc_sel), 0);
        step();
        check("jalr_fetch", 32'(dut.state), FETCH);

        // LUI writes the immediate
        to_exec(32'h123450B7);
        check("lui_rw", 32'(bus.reg_write), 1);
        check("lui_wb", 32'(bus.wb_sel), 2);
        step();

        // Illegal opcode traps and stays
        bus.instr = 32'h0000007F;
        #1;
        step();
        check("ill_decode", 32'(dut.state), DECODE);
        step();
        check("ill_trap", 32'(dut.state), TRAP);
        check("ill_flag", 32'(bus.illegal), 1);
        check("ill_mem_req", 32'(bus.mem_req), 0);
        step();
        step();
        check("ill_sticky", 32'(bus.illegal), 1);
        check("ill_stay", 32'(dut.state), TRAP);

        // Reset pulse clears the trap
        rst_n = 1'b0;
        #1;
        check("rp_illegal", 32'(bus.illegal), 0);
        check("rp_state", 32'(dut.state), FETCH);
        check("rp_mem_req", 32'(bus.mem_req), 0);
        step();
        rst_n = 1'b1;

        // Reserved branch funct3 traps
        to_exec(32'h00208063);
        step();
        bus.instr = 32'h0020A063;
        #1;
        step();
        step();
        check("rsv_trap", 32'(dut.state), TRAP);
        check("rsv_flag", 32'(bus.illegal), 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;

        // Reset mid-MEM drops the request at once
        to_exec(32'h0000A183);
        bus.mem_ready = 1'b0;
        step();
        check("ab_mem_req_pre", 32'(bus.mem_req), 1);
        rst_n = 1'b0;
        #1;
        check("ab_mem_req", 32'(bus.mem_req), 0);
        check("ab_state", 32'(dut.state), FETCH);
        step();
        rst_n = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
